// File: rtl/fft_input_loader_pkg.sv
// Shared constants and loader state type for the FFT input loader.
package fft_consts;

  localparam int N     = 16;
  localparam int DW    = 32;
  localparam int LOG2N = $clog2(N);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/fft_input_loader_bitrev.sv
// Combinational index mapper: bit-reversed when REVERSE=1, pass-through otherwise.
module fft_bitrev #(
  parameter int W       = 4,
  parameter bit REVERSE = 1'b1
) (
  input  logic [W-1:0] idx_i,
  output logic [W-1:0] rev_o
);

  if (REVERSE) begin : g_rev
    for (genvar b = 0; b < W; b++) begin : g_bit
      assign rev_o[b] = idx_i[W-1-b];
    end
  end else begin : g_pass
    assign rev_o = idx_i;
  end

endmodule

// File: rtl/fft_input_loader.sv
// Streams one frame of samples into port A of the FFT dual-port RAM, then holds it until frame_ack.
// Define FFT_LOADER_BITREV_EN for bit-reversed (DIT) write addresses; natural order otherwise.
module fft_input_loader
  import fft_consts::*;
#(
  parameter int N_PTS  = N,
  parameter int DATA_W = DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       ram_ena,
  output logic                       ram_wea,
  output logic [$clog2(N_PTS)-1:0]   ram_addr,
  output logic [DATA_W-1:0]          ram_din,
  output logic                       frame_ready,
  input  logic                       frame_ack,
  output logic                       frame_err,
  output logic [7:0]                 frame_cnt
);

  localparam int AW = $clog2(N_PTS);

`ifdef FFT_LOADER_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  ld_state_e         state_q, state_d;
  logic              armed_q;
  logic [AW-1:0]     idx_q, idx_d;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] din_q;
  logic              fr_q, fr_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              accept;
  logic              at_end;
  logic [AW-1:0]     map_idx;

  fft_bitrev #(
    .W       (AW),
    .REVERSE (BITREV)
  ) u_map (
    .idx_i (idx_q),
    .rev_o (map_idx)
  );

  assign at_end = (idx_q == AW'(N_PTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (accept && at_end) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (frame_ack) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // armed_q keeps s_ready low until the first edge after reset release.
  always_comb begin
    s_ready = armed_q && (state_q == ST_LOAD);
    accept  = s_valid && s_ready;
  end

  always_comb begin
    idx_d = idx_q;
    if (accept) begin
      idx_d = (at_end || s_last) ? '0 : idx_q + AW'(1);
    end
    // Early last and missing last are both a mismatch between s_last and the frame end.
    err_d = accept && (s_last != at_end);
    fr_d  = fr_q;
    if (state_q == ST_DRAIN) begin
      fr_d = 1'b1;
    end else if ((state_q == ST_HOLD) && frame_ack) begin
      fr_d = 1'b0;
    end
    cnt_d = (state_q == ST_DRAIN) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      fr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      idx_q   <= idx_d;
      wr_q    <= accept;
      if (accept) begin
        addr_q <= map_idx;
        din_q  <= s_data;
      end
      fr_q    <= fr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ram_ena     = wr_q;
  assign ram_wea     = wr_q;
  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign frame_ready = fr_q;
  assign frame_err   = err_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL take parameter N_PTS, default fft_consts::N; points per frame, power of two, at least 4.
REQ-002 SHALL take parameter DATA_W, default fft_consts::DW; sample width in bits.
REQ-003 SHALL have port clk, input, 1 bit; the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1 bit; upstream sample valid.
REQ-006 SHALL have port s_data, input, DATA_W bits; sample payload.
REQ-007 SHALL have port s_last, input, 1 bit; upstream end-of-frame marker.
REQ-008 SHALL have port s_ready, output, 1 bit; loader accepts a sample.
REQ-009 SHALL have ports ram_ena and ram_wea, output, 1 bit each; RAM port-A enable and write strobe.
REQ-010 SHALL have port ram_addr, output, LOG2N bits; RAM port-A address.
REQ-011 SHALL have port ram_din, output, DATA_W bits; RAM port-A write data.
REQ-012 SHALL have port frame_ready, output, 1 bit; full frame resident in RAM.
REQ-013 SHALL have port frame_ack, input, 1 bit; FFT core has released the buffer.
REQ-014 SHALL have port frame_err, output, 1 bit; one-cycle pulse on a framing error.
REQ-015 SHALL have port frame_cnt, output, 8 bits; count of completed frames.

Function
REQ-016 SHALL accept a beat on each rising edge where s_valid and s_ready are both 1.
REQ-017 SHALL implement states LOAD, DRAIN and HOLD; s_ready is 1 only in LOAD.
REQ-018 SHALL hold a LOG2N-bit sample index idx, starting at 0, incremented per accepted beat.
REQ-019 SHALL register the write: beat accepted at edge k drives ram_ena=ram_wea=1, ram_addr=map(idx), ram_din=s_data for cycle k+1 only.
REQ-020 SHALL hold ram_ena and ram_wea at 0 in every cycle with no pending write.
REQ-021 SHALL move LOAD to DRAIN on the beat with idx=N_PTS-1, wrapping idx to 0.
REQ-022 SHALL move DRAIN to HOLD unconditionally after one cycle, registering frame_ready=1 and incrementing frame_cnt (mod 256).
REQ-023 SHALL hold frame_ready at 1 throughout HOLD, independent of s_valid.
REQ-024 SHALL move HOLD to LOAD on the first edge with frame_ack=1, clearing frame_ready at that edge.
REQ-025 SHALL ignore frame_ack in LOAD and DRAIN.
REQ-026 SHALL treat s_last=1 on a beat with idx<N_PTS-1 as an early last: the beat is still written, idx resets to 0, state stays LOAD, frame_err pulses the next cycle, and frame_cnt is unchanged.
REQ-027 SHALL treat s_last=0 on the beat with idx=N_PTS-1 as a missing last: the frame completes normally and frame_err pulses the next cycle.

Reset
REQ-028 SHALL, while rst_n=0, force state=LOAD, idx=0, ram_ena=ram_wea=0, ram_addr=0, ram_din=0, frame_ready=0, frame_err=0 and frame_cnt=0.
REQ-029 SHALL drive s_ready=0 while rst_n=0, and s_ready=1 from the first edge after release.
REQ-030 SHALL discard any partially loaded frame on reset mid-operation, with no write strobe in the cycle after release.

Configuration
REQ-031 SHALL, with FFT_LOADER_BITREV_EN defined, set map(idx) to the LOG2N-bit bit-reversal of idx (decimation-in-time input order).
REQ-032 SHALL, without FFT_LOADER_BITREV_EN, set map(idx)=idx (natural order), with timing identical to REQ-031.

Structure
REQ-033 SHALL place LOG2N = $clog2(N) and the loader state enum typedef in package fft_consts.
REQ-034 SHALL implement the bit reversal in a combinational sub-module fft_bitrev, parameterised by width.
REQ-035 SHALL drive port A of the existing dual-port RAM through the dp_ram_if signals, leaving port B to the FFT core.

Verification (N=16, DW=32)
REQ-036 SHALL cover: 16 beats data=0..15, s_last on the 16th, BITREV on -> writes addr 0,8,4,12,...,15 with din 0..15; frame_ready high 2 cycles after the last beat; frame_cnt=1.
REQ-037 SHALL cover: the same stream with BITREV off -> addr equals din (0..15).
REQ-038 SHALL cover: 20 beats offered back-to-back -> exactly 16 accepted; s_ready=0 until frame_ack; then the 17th beat is written to addr 0.
REQ-039 SHALL cover: s_last on the 5th beat -> frame_err pulses once; the next beat is written to addr map(0); frame_cnt is unchanged.
REQ-040 SHALL cover: rst_n low after 9 beats -> all outputs return to reset values; the following 16-beat frame completes with frame_cnt=1.
REQ-041 SHALL cover: frame_ack held high through LOAD and DRAIN -> no effect; leaving HOLD requires ack in HOLD.
